// File: rtl/fp21_mul_pipe_pkg.sv
// Shared FP21 format constants, operand class record and packing helpers
// for the FP21 arithmetic datapath.
package fp21_mul_pipe_pkg;

  localparam int EXP  = 7;
  localparam int FRAC = 13;
  localparam int W    = EXP + FRAC + 1;
  localparam int MW   = FRAC + 1;
  localparam int EW   = EXP + 3;
  localparam int BIAS = (1 << (EXP - 1)) - 1;

  localparam logic [W-1:0] FP21_QNAN    = 21'h0FF000;
  localparam logic [W-1:0] FP21_POS_INF = 21'h0FE000;
  localparam logic [W-1:0] FP21_NEG_INF = 21'h1FE000;

  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = EW'(0);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP) - 1);

  typedef struct packed {
    logic snan;
    logic qnan;
    logic inf;
    logic zero;
    logic denorm;
    logic normal;
  } fp21_class_t;

  function automatic logic [W-1:0] fp21_inf(input logic sign);
    return sign ? FP21_NEG_INF : FP21_POS_INF;
  endfunction

  function automatic logic [W-1:0] fp21_zero(input logic sign);
    return {sign, {(W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/FP21_special_case_check.sv
// Splits an FP21 word into sign/exponent/hidden-bit mantissa and classifies it.
// Denormals get a zero hidden bit; the consumer treats them as zero.
module FP21_special_case_check
  import fp21_mul_pipe_pkg::*;
(
  input  logic [W-1:0]   x,
  output logic           sign,
  output logic [EXP-1:0] exp,
  output logic [MW-1:0]  mant,
  output fp21_class_t    cls
);

  logic [FRAC-1:0] frac_s;
  logic            exp_ones_s;
  logic            exp_zero_s;
  logic            frac_nz_s;

  assign sign       = x[W-1];
  assign exp        = x[W-2:FRAC];
  assign frac_s     = x[FRAC-1:0];
  assign exp_ones_s = &exp;
  assign exp_zero_s = ~(|exp);
  assign frac_nz_s  = |frac_s;

  assign cls.snan   = exp_ones_s & frac_nz_s & ~frac_s[FRAC-1];
  assign cls.qnan   = exp_ones_s & frac_s[FRAC-1];
  assign cls.inf    = exp_ones_s & ~frac_nz_s;
  assign cls.zero   = exp_zero_s & ~frac_nz_s;
  assign cls.denorm = exp_zero_s & frac_nz_s;
  assign cls.normal = ~exp_ones_s & ~exp_zero_s;

  assign mant = {cls.normal, frac_s};

endmodule

// File: rtl/fp21_round_pack.sv
// Combinational round-to-nearest-even and pack with overflow-to-inf and
// flush-to-zero; shared by FP21 arithmetic units.
module fp21_round_pack
  import fp21_mul_pipe_pkg::*;
(
  input  logic                 sign,
  input  logic signed [EW-1:0] e,
  input  logic [MW-1:0]        mant,
  input  logic                 guard,
  input  logic                 sticky,
  output logic [W-1:0]         y,
  output logic                 overflow,
  output logic                 underflow
);

  logic                 rnd_up_s;
  logic [MW:0]          sum_s;
  logic [FRAC-1:0]      frac_s;
  logic signed [EW-1:0] e_adj_s;

  assign rnd_up_s = guard & (sticky | mant[0]);
  assign sum_s    = {1'b0, mant} + {{MW{1'b0}}, rnd_up_s};
  // A carry out can only come from an all-ones mantissa, so the fraction becomes zero.
  assign frac_s   = sum_s[MW] ? sum_s[FRAC:1] : sum_s[FRAC-1:0];
  assign e_adj_s  = sum_s[MW] ? (e + E_ONE) : e;

  // Saturate or flush on the post-rounding exponent.
  always_comb begin
    y         = {W{1'b0}};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (e_adj_s >= E_MAX) begin
      y        = fp21_inf(sign);
      overflow = 1'b1;
    end else if (e_adj_s <= E_ZERO) begin
      y         = fp21_zero(sign);
      underflow = 1'b1;
    end else begin
      y = {sign, e_adj_s[EXP-1:0], frac_s};
    end
  end

endmodule

// File: rtl/fp21_mul_pipe.sv
// Three-stage FP21 multiplier (classify, multiply/normalise, round/pack) with
// valid/ready flow control; all stages advance together and hold on a stalled output.
module fp21_mul_pipe
  import fp21_mul_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         flag_invalid,
  output logic         flag_overflow,
  output logic         flag_underflow
);

  logic            advance_s;
  logic            sign_a_s, sign_b_s;
  logic [EXP-1:0]  exp_a_s, exp_b_s;
  logic [MW-1:0]   mant_a_s, mant_b_s;
  fp21_class_t     cls_a_s, cls_b_s;

  logic            valid1_r, sign1_r;
  fp21_class_t     cls_a1_r, cls_b1_r;
  logic [EXP-1:0]  exp_a1_r, exp_b1_r;
  logic [MW-1:0]   mant_a1_r, mant_b1_r;

  logic [2*MW-1:0]      prod_s;
  logic signed [EW-1:0] esum_s, e2_s;
  logic [MW-1:0]        mant2_s;
  logic                 guard2_s, sticky2_s;

  logic                 valid2_r, sign2_r, guard2_r, sticky2_r;
  fp21_class_t          cls_a2_r, cls_b2_r;
  logic signed [EW-1:0] e2_r;
  logic [MW-1:0]        mant2_r;

  logic [W-1:0] rp_y_s, s3_y_s;
  logic         rp_ovf_s, rp_unf_s, s3_inv_s, s3_ovf_s, s3_unf_s;
  logic         nan_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;

  logic         valid3_r, inv3_r, ovf3_r, unf3_r;
  logic [W-1:0] y3_r;

  assign advance_s = ~valid3_r | out_ready;
  assign in_ready  = advance_s;

  FP21_special_case_check u_chk_a (
    .x(a), .sign(sign_a_s), .exp(exp_a_s), .mant(mant_a_s), .cls(cls_a_s)
  );

  FP21_special_case_check u_chk_b (
    .x(b), .sign(sign_b_s), .exp(exp_b_s), .mant(mant_b_s), .cls(cls_b_s)
  );

  // S1: capture classified operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_r  <= 1'b0;
      sign1_r   <= 1'b0;
      cls_a1_r  <= '0;
      cls_b1_r  <= '0;
      exp_a1_r  <= {EXP{1'b0}};
      exp_b1_r  <= {EXP{1'b0}};
      mant_a1_r <= {MW{1'b0}};
      mant_b1_r <= {MW{1'b0}};
    end else if (advance_s) begin
      valid1_r  <= in_valid;
      sign1_r   <= sign_a_s ^ sign_b_s;
      cls_a1_r  <= cls_a_s;
      cls_b1_r  <= cls_b_s;
      exp_a1_r  <= exp_a_s;
      exp_b1_r  <= exp_b_s;
      mant_a1_r <= mant_a_s;
      mant_b1_r <= mant_b_s;
    end
  end

  assign prod_s = {{MW{1'b0}}, mant_a1_r} * {{MW{1'b0}}, mant_b1_r};
  assign esum_s = $signed({{(EW-EXP){1'b0}}, exp_a1_r})
                + $signed({{(EW-EXP){1'b0}}, exp_b1_r}) - E_BIAS;

  // Normalise a product in [2,4) down to [1,2), keeping guard and sticky for rounding.
  always_comb begin
    mant2_s   = prod_s[2*MW-2:MW-1];
    guard2_s  = prod_s[MW-2];
    sticky2_s = |prod_s[MW-3:0];
    e2_s      = esum_s;
    if (prod_s[2*MW-1]) begin
      mant2_s   = prod_s[2*MW-1:MW];
      guard2_s  = prod_s[MW-1];
      sticky2_s = |prod_s[MW-2:0];
      e2_s      = esum_s + E_ONE;
    end else begin
      mant2_s   = prod_s[2*MW-2:MW-1];
      guard2_s  = prod_s[MW-2];
      sticky2_s = |prod_s[MW-3:0];
      e2_s      = esum_s;
    end
  end

  // S2: capture normalised product and carry the class bits forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid2_r  <= 1'b0;
      sign2_r   <= 1'b0;
      cls_a2_r  <= '0;
      cls_b2_r  <= '0;
      e2_r      <= E_ZERO;
      mant2_r   <= {MW{1'b0}};
      guard2_r  <= 1'b0;
      sticky2_r <= 1'b0;
    end else if (advance_s) begin
      valid2_r  <= valid1_r;
      sign2_r   <= sign1_r;
      cls_a2_r  <= cls_a1_r;
      cls_b2_r  <= cls_b1_r;
      e2_r      <= e2_s;
      mant2_r   <= mant2_s;
      guard2_r  <= guard2_s;
      sticky2_r <= sticky2_s;
    end
  end

  fp21_round_pack u_round_pack (
    .sign(sign2_r), .e(e2_r), .mant(mant2_r), .guard(guard2_r), .sticky(sticky2_r),
    .y(rp_y_s), .overflow(rp_ovf_s), .underflow(rp_unf_s)
  );

  assign nan_s    = cls_a2_r.snan | cls_a2_r.qnan | cls_b2_r.snan | cls_b2_r.qnan;
  assign inf_a_s  = cls_a2_r.inf;
  assign inf_b_s  = cls_b2_r.inf;
  assign zero_a_s = cls_a2_r.zero | cls_a2_r.denorm;
  assign zero_b_s = cls_b2_r.zero | cls_b2_r.denorm;

  // Special-case priority; a bubble yields zero data and no flags.
  always_comb begin
    s3_y_s   = {W{1'b0}};
    s3_inv_s = 1'b0;
    s3_ovf_s = 1'b0;
    s3_unf_s = 1'b0;
    if (!valid2_r) begin
      s3_y_s = {W{1'b0}};
    end else if (nan_s | (inf_a_s & zero_b_s) | (zero_a_s & inf_b_s)) begin
      s3_y_s   = FP21_QNAN;
      s3_inv_s = 1'b1;
    end else if (inf_a_s | inf_b_s) begin
      s3_y_s = fp21_inf(sign2_r);
    end else if (zero_a_s | zero_b_s) begin
      s3_y_s = fp21_zero(sign2_r);
    end else if (cls_a2_r.normal & cls_b2_r.normal) begin
      s3_y_s   = rp_y_s;
      s3_ovf_s = rp_ovf_s;
      s3_unf_s = rp_unf_s;
    end else begin
      s3_y_s = {W{1'b0}};
    end
  end

  // S3: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid3_r <= 1'b0;
      y3_r     <= {W{1'b0}};
      inv3_r   <= 1'b0;
      ovf3_r   <= 1'b0;
      unf3_r   <= 1'b0;
    end else if (advance_s) begin
      valid3_r <= valid2_r;
      y3_r     <= s3_y_s;
      inv3_r   <= s3_inv_s;
      ovf3_r   <= s3_ovf_s;
      unf3_r   <= s3_unf_s;
    end
  end

  assign out_valid      = valid3_r;
  assign y              = y3_r;
  assign flag_invalid   = inv3_r;
  assign flag_overflow  = ovf3_r;
  assign flag_underflow = unf3_r;

endmodule
